// File: rtl/distance_frame_proc_pkg.sv
// Shared state encoding and width constants for the distance-frame processor.
// The StChk state exists only when CHECKSUM_EN is defined.
package distance_frame_proc_pkg;

   localparam int unsigned NUM_W       = 25;
   localparam int unsigned DIV_CYCLES  = 25;
   localparam int unsigned SAMPLE_BITS = 16;
   localparam int unsigned ANGLE_BITS  = 16;

   typedef enum logic [3:0] {
      StSkip,
      StLen,
      StFsaL,
      StFsaH,
      StLsaL,
      StLsaH,
      StSampL,
      StSampH,
`ifdef CHECKSUM_EN
      StChk,
`endif
      StDivLo,
      StDivHi,
      StDone
   } state_e;

endpackage

// File: rtl/distance_frame_proc_seq_divider.sv
// Restoring divider, one quotient bit per cycle. The first iteration runs on the start edge,
// so done pulses DIV_CYCLES cycles after start; the quotient keeps its low ANGLE_BITS bits.
module distance_frame_proc_seq_divider
   import distance_frame_proc_pkg::*;
#(
   parameter int unsigned LEN_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NUM_W-1:0]      dividend,
   input  logic [LEN_W-1:0]      divisor,
   output logic [ANGLE_BITS-1:0] quotient,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

   logic [NUM_W-1:0]      dvd_q, dvd_d, dvd_src;
   logic [LEN_W-1:0]      rem_q, rem_d, rem_src, diff;
   logic [ANGLE_BITS-1:0] quo_q, quo_d, quo_src;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [LEN_W:0]        trial;
   logic                  ge;

   always_comb begin
      dvd_src = start ? dividend : dvd_q;
      rem_src = start ? '0 : rem_q;
      quo_src = start ? '0 : quo_q;
      trial   = {rem_src, dvd_src[NUM_W-1]};
      ge      = trial >= {1'b0, divisor};
      // When ge holds the true difference is below divisor, so the low bits are exact.
      diff    = trial[LEN_W-1:0] - divisor;

      dvd_d  = dvd_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start || busy_q) begin
         dvd_d = {dvd_src[NUM_W-2:0], 1'b0};
         rem_d = ge ? diff : trial[LEN_W-1:0];
         quo_d = {quo_src[ANGLE_BITS-2:0], ge};
         if (start) begin
            cnt_d  = CntW'(DIV_CYCLES - 1);
            busy_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dvd_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign quotient = quo_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: rtl/distance_frame_proc.sv
// Distance-frame processor: streaming min/max/hit extraction with interpolated angles.
// Define CHECKSUM_EN to require a trailing XOR byte covering LEN through the last sample.
module distance_frame_proc
   import distance_frame_proc_pkg::*;
#(
   parameter int unsigned SKIP_BYTES = 3,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned MAX_LEN    = 255,
   parameter int unsigned SAMPLE_W   = 16,
   parameter int unsigned HIT_W      = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [7:0]          datain,
   input  logic                flashin,
   input  logic [SAMPLE_W-1:0] hit_threshold,
   output logic [15:0]         lowest,
   output logic [15:0]         highest,
   output logic [15:0]         lowest_dist,
   output logic [15:0]         highest_dist,
   output logic [HIT_W-1:0]    hitvector,
   output logic                frame_err,
   output logic                busy,
   output logic                flashout
);

   localparam int unsigned SkipW = $clog2(SKIP_BYTES + 1);

   state_e                 state_q, state_d;
   logic [SkipW-1:0]       skip_q, skip_d;
   logic [LEN_W-1:0]       len_q, len_d, idx_q, idx_d, min_idx_q, min_idx_d, max_idx_q, max_idx_d;
   logic [SAMPLE_W-1:0]    thr_q, thr_d;
   logic [7:0]             lo_byte_q, lo_byte_d;
   logic [ANGLE_BITS-1:0]  fsa_q, fsa_d, lsa_q, lsa_d, min_ang_q, min_ang_d, max_ang_q, max_ang_d;
   logic [SAMPLE_BITS-1:0] min_q, min_d, max_q, max_d, sample;
   logic [HIT_W-1:0]       hits_q, hits_d, hitvec_q, hitvec_d;
   logic                   valid_q, valid_d, err_q, err_d, ferr_q, ferr_d, flash_q, flash_d;
   logic [1:0]             wait_q, wait_d;
   logic [15:0]            low_q, low_d, high_q, high_d, lowd_q, lowd_d, highd_q, highd_d;
   logic                   end_samples;
`ifdef CHECKSUM_EN
   logic [7:0]             csum_q, csum_d;
`endif

   logic [LEN_W-1:0]      idx_sel, weight;
   logic [NUM_W-1:0]      num;
   logic [ANGLE_BITS-1:0] quotient;
   logic                  div_start, div_busy, div_done;

   assign idx_sel   = (state_q == StDivHi) ? max_idx_q : min_idx_q;
   assign weight    = len_q - LEN_W'(1) - idx_sel;
   assign num       = NUM_W'(fsa_q) * NUM_W'(weight) + NUM_W'(lsa_q) * NUM_W'(idx_sel);
   assign div_start = (state_q == StDivLo || state_q == StDivHi) && !div_busy && !div_done;

   distance_frame_proc_seq_divider #(
      .LEN_W (LEN_W)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (num),
      .divisor  (len_q - LEN_W'(1)),
      .quotient (quotient),
      .busy     (div_busy),
      .done     (div_done)
   );

   always_comb begin
      state_d     = state_q;
      skip_d      = skip_q;
      len_d       = len_q;
      idx_d       = idx_q;
      min_idx_d   = min_idx_q;
      max_idx_d   = max_idx_q;
      thr_d       = thr_q;
      lo_byte_d   = lo_byte_q;
      fsa_d       = fsa_q;
      lsa_d       = lsa_q;
      min_ang_d   = min_ang_q;
      max_ang_d   = max_ang_q;
      min_d       = min_q;
      max_d       = max_q;
      hits_d      = hits_q;
      valid_d     = valid_q;
      err_d       = err_q;
      wait_d      = wait_q;
      low_d       = low_q;
      high_d      = high_q;
      lowd_d      = lowd_q;
      highd_d     = highd_q;
      hitvec_d    = hitvec_q;
      ferr_d      = ferr_q;
      flash_d     = 1'b0;
      end_samples = 1'b0;
      sample      = {datain, lo_byte_q};
`ifdef CHECKSUM_EN
      csum_d      = csum_q;
`endif

      unique case (state_q)
         StSkip: if (flashin) begin
            if (skip_q == SkipW'(SKIP_BYTES - 1)) begin
               skip_d  = '0;
               state_d = StLen;
            end else begin
               skip_d = skip_q + SkipW'(1);
            end
         end
         StLen: if (flashin) begin
            len_d     = LEN_W'(datain);
            thr_d     = hit_threshold;
            idx_d     = '0;
            min_d     = '0;
            max_d     = '0;
            min_idx_d = '0;
            max_idx_d = '0;
            hits_d    = '0;
            valid_d   = 1'b0;
            err_d     = 1'b0;
            if (len_d == '0 || 32'(len_d) > MAX_LEN) begin
               err_d   = 1'b1;
               wait_d  = 2'd2;
               state_d = StDone;
            end else begin
               state_d = StFsaL;
            end
         end
         StFsaL: if (flashin) begin
            lo_byte_d = datain;
            state_d   = StFsaH;
         end
         StFsaH: if (flashin) begin
            fsa_d   = sample;
            state_d = StLsaL;
         end
         StLsaL: if (flashin) begin
            lo_byte_d = datain;
            state_d   = StLsaH;
         end
         StLsaH: if (flashin) begin
            lsa_d   = sample;
            state_d = StSampL;
         end
         StSampL: if (flashin) begin
            lo_byte_d = datain;
            state_d   = StSampH;
         end
         StSampH: if (flashin) begin
            if (sample != '0) begin
               if (!valid_q || sample < min_q) begin
                  min_d     = sample;
                  min_idx_d = idx_q;
               end
               if (!valid_q || sample > max_q) begin
                  max_d     = sample;
                  max_idx_d = idx_q;
               end
               valid_d = 1'b1;
               for (int k = 0; k < int'(HIT_W); k++) begin
                  if (int'(idx_q) == k && sample < thr_q) hits_d[k] = 1'b1;
               end
            end
            if (idx_q == len_q - LEN_W'(1)) begin
`ifdef CHECKSUM_EN
               state_d = StChk;
`else
               end_samples = 1'b1;
`endif
            end else begin
               idx_d   = idx_q + LEN_W'(1);
               state_d = StSampL;
            end
         end
`ifdef CHECKSUM_EN
         StChk: if (flashin) begin
            if (datain != csum_q) begin
               err_d   = 1'b1;
               wait_d  = 2'd2;
               state_d = StDone;
            end else begin
               end_samples = 1'b1;
            end
         end
`endif
         StDivLo: if (div_done) begin
            min_ang_d = quotient;
            state_d   = StDivHi;
         end
         StDivHi: if (div_done) begin
            max_ang_d = quotient;
            wait_d    = 2'd0;
            state_d   = StDone;
         end
         StDone: begin
            if (wait_q != 2'd0) begin
               wait_d = wait_q - 2'd1;
            end else begin
               flash_d  = 1'b1;
               skip_d   = '0;
               state_d  = StSkip;
               ferr_d   = err_q;
               low_d    = err_q ? '0 : min_ang_q;
               high_d   = err_q ? '0 : max_ang_q;
               lowd_d   = err_q ? '0 : min_q;
               highd_d  = err_q ? '0 : max_q;
               hitvec_d = err_q ? '0 : hits_q;
            end
         end
         default: state_d = StSkip;
      endcase

      // Short paths wait two extra cycles so they match the fixed 3-cycle latency.
      if (end_samples) begin
         wait_d  = 2'd2;
         state_d = StDone;
         if (!valid_d) begin
            err_d = 1'b1;
         end else if (len_q == LEN_W'(1)) begin
            min_ang_d = fsa_q;
            max_ang_d = fsa_q;
         end else begin
            wait_d  = 2'd0;
            state_d = StDivLo;
         end
      end

`ifdef CHECKSUM_EN
      if (flashin) begin
         if (state_q == StLen) begin
            csum_d = datain;
         end else if (state_q inside {StFsaL, StFsaH, StLsaL, StLsaH, StSampL, StSampH}) begin
            csum_d = csum_q ^ datain;
         end
      end
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StSkip;
         skip_q    <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         min_idx_q <= '0;
         max_idx_q <= '0;
         thr_q     <= '0;
         lo_byte_q <= '0;
         fsa_q     <= '0;
         lsa_q     <= '0;
         min_ang_q <= '0;
         max_ang_q <= '0;
         min_q     <= '0;
         max_q     <= '0;
         hits_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         wait_q    <= '0;
         low_q     <= '0;
         high_q    <= '0;
         lowd_q    <= '0;
         highd_q   <= '0;
         hitvec_q  <= '0;
         ferr_q    <= 1'b0;
         flash_q   <= 1'b0;
`ifdef CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         skip_q    <= skip_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         min_idx_q <= min_idx_d;
         max_idx_q <= max_idx_d;
         thr_q     <= thr_d;
         lo_byte_q <= lo_byte_d;
         fsa_q     <= fsa_d;
         lsa_q     <= lsa_d;
         min_ang_q <= min_ang_d;
         max_ang_q <= max_ang_d;
         min_q     <= min_d;
         max_q     <= max_d;
         hits_q    <= hits_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         wait_q    <= wait_d;
         low_q     <= low_d;
         high_q    <= high_d;
         lowd_q    <= lowd_d;
         highd_q   <= highd_d;
         hitvec_q  <= hitvec_d;
         ferr_q    <= ferr_d;
         flash_q   <= flash_d;
`ifdef CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign lowest       = low_q;
   assign highest      = high_q;
   assign lowest_dist  = lowd_q;
   assign highest_dist = highd_q;
   assign hitvector    = hitvec_q;
   assign frame_err    = ferr_q;
   assign flashout     = flash_q;
   assign busy         = (state_q != StSkip && state_q != StLen) || flash_q;

endmodule

// File: doc/distance_frame_proc.md
Name: distance_frame_proc

Overview:
- Parametrised successor to the team's UART distance-frame processor.
- Consumes a byte stream framed as: SKIP_BYTES address bytes, then length N, then FSA (first-sample angle) as 16-bit little-endian, then LSA (last-sample angle) as 16-bit little-endian, then N samples as 16-bit little-endian.
- Tracks min/max distance on the fly, so no sample RAM is needed. Interpolates the angle of each with one shared sequential divider, and builds a parametrised hit vector.
- Sits between the UART receiver and the motion controller.

Parameters:
- SKIP_BYTES, 3, number of leading address bytes discarded per frame.
- LEN_W, 8, width of the length field.
- MAX_LEN, 255, largest accepted N; must be ≤ 2^LEN_W−1.
- SAMPLE_W, 16, distance/angle width. Fixed at 16 by the byte framing.
- HIT_W, 16, number of leading samples reported in hitvector.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- datain  in  8  received byte.
- flashin  in  1  one-cycle strobe: datain valid.
- hit_threshold  in  SAMPLE_W  sample is a hit if valid and strictly below this value. Sampled at the LEN byte.
- lowest  out  16  interpolated angle of the minimum-distance sample.
- highest  out  16  interpolated angle of the maximum-distance sample.
- lowest_dist  out  16  minimum distance value.
- highest_dist  out  16  maximum distance value.
- hitvector  out  HIT_W  bit k = sample k is a hit.
- frame_err  out  1  last completed frame was rejected.
- busy  out  1  high from the LEN byte until the flashout cycle inclusive.
- flashout  out  1  one-cycle result strobe.

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; state SKIP; skip counter 0.
  - Reset mid-frame or mid-divide abandons the frame with no flashout.
- States: SKIP, LEN, FSA_L, FSA_H, LSA_L, LSA_H, SAMP_L, SAMP_H, [CHK], DIV_LO, DIV_HI, DONE.
  - Byte-consuming states advance only on flashin.
  - DIV_LO, DIV_HI and DONE ignore flashin; bytes arriving in them are dropped.
- SKIP: count flashin up to SKIP_BYTES, then go to LEN.
- LEN:
  - Latch N and hit_threshold; clear the running min/max, valid flag and hit bits.
  - If N=0 or N>MAX_LEN: set the error flag, drain nothing, go to DONE.
- Samples:
  - Index k runs 0..N−1.
  - Sample = {high byte, low byte}; evaluated at the SAMP_H byte.
- Sample rules:
  - A sample value of 0 is invalid: excluded from min/max, and its hit bit is 0.
  - Min update only on strictly less-than, max update only on strictly greater-than. Ties keep the first index.
  - For k<HIT_W, hitvector bit k = valid && sample < threshold. Bits k≥N stay 0.
- After the last sample, go to [CHK] or DIV_LO.
- No valid samples in the frame: error, go to DONE.
- Angle arithmetic, all unsigned:
  - num = FSA·(N−1−i) + LSA·i, 25 bits.
  - Angle = floor(num/(N−1)), truncated to 16 bits. The result always fits because it is a weighted mean.
  - N=1: angle = FSA, no divide.
- Divider: a single restoring divider, 1 quotient bit per cycle (25 cycles), used first for the min index (DIV_LO) and then for the max index (DIV_HI).
- DONE:
  - Update all outputs together and pulse flashout for exactly 1 cycle, then return to SKIP.
  - On error: lowest, highest, lowest_dist, highest_dist and hitvector are 0, and frame_err=1.
  - Otherwise frame_err=0.
  - Outputs hold until the next DONE.
- Latency, last byte to flashout:
  - 53 cycles for N≥2 (2×25 divide + 3).
  - 3 cycles for N=1 or error.

Optional Feature:
- CHECKSUM_EN defined:
  - After the samples, one extra byte is expected in CHK. It equals the XOR of every byte from LEN through the last sample byte.
  - On mismatch: error path, outputs zeroed, frame_err=1.
  - The checksum byte is still consumed when N is otherwise invalid? No: on the length error no further bytes are consumed.
- CHECKSUM_EN undefined: CHK state absent; the divide starts directly after the last sample.

Decomposition:
- Shared package holds:
  - the state enum;
  - the constants DIV_CYCLES=25 and NUM_W=25;
  - the sample and angle width constants.
- Sub-module seq_divider: start/done handshake, NUM_W-bit dividend, LEN_W-bit divisor, 16-bit quotient. It is reusable by other blocks.

Test Plan:
- Nominal frame:
  - Stimulus: SKIP 3, N=4, FSA=0x0000, LSA=0x0300, samples 0x0500,0x0200,0x0800,0x0350, threshold 0x0400.
  - Response: lowest=0x0100, highest=0x0200, lowest_dist=0x0200, highest_dist=0x0800, hitvector=0x000A, frame_err=0, flashout 53 cycles after the last byte.
- N=1: FSA=0x1234, LSA=0x9999, sample 0x0100, threshold 0x0400 → lowest=highest=0x1234, hitvector=0x0001.
- N=0 → flashout with frame_err=1 and all outputs 0. A following valid frame processes normally.
- Invalid samples and ties:
  - N=4, samples 0x0000,0x0300,0x0300,0x0000, FSA=0, LSA=0x0300 → min and max both at index 1 (angle 0x0100); hitvector bits 0 and 3 are 0.
  - All-zero samples → frame_err=1.
- Disruption:
  - Reset asserted during SAMP_H of sample 2 → no flashout, all outputs 0. A full frame after release gives the nominal result.
  - Extra flashin bytes during DIV_LO are dropped and do not corrupt results.
- CHECKSUM_EN: nominal frame with the correct XOR byte → nominal result. Flip one bit of the checksum → frame_err=1.
